// File: rtl/uart_tx_engine_if.sv
// Byte-offer handshake between the UART MMIO slave and the transmit engine.
interface uart_tx_engine_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmit back end: byte FIFO feeding a serialiser at a fixed baud divisor.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high); chains directly into START if bytes remain
module uart_tx_engine #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    uart_tx_engine_if.slave             in_if,
    input  logic                        flush,
    output logic                        txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          in_ready_q;

    logic          bit_end;
    logic          push;
    logic          pop;

    // Handshake qualification and next FIFO occupancy; flush overrides both push and pop.
    always_comb begin
        bit_end = (baud_q == BW'(CLK_DIV - 1));
        push    = in_if.in_valid && in_ready_q && !flush;
        pop     = !flush && (count_q != '0) &&
                  ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_if.in_data;
        end
    end

    // FIFO pointers, occupancy and registered ready (no same-cycle pop bypass).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // Frame sequencer; txd is registered from the state being entered so it lines up with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= START;
                        txd_q   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                        txd_q     <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign txd            = txd_q;
    assign tx_busy        = (state_q != IDLE);
    assign fifo_count     = count_q;

endmodule
